// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-2 Booth multiplier.
// Two signed WIDTH-bit operands are turned into a signed 2*WIDTH-bit product
// by WIDTH add/subtract-and-shift iterations, one per clock.
module booth_seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_reg;
    // A carries one extra bit so that -M is representable for M = -2^(WIDTH-1).
    logic [WIDTH:0]       a_reg;
    logic [WIDTH:0]       m_reg;
    logic [WIDTH-1:0]     q_reg;
    logic                 q_m1_reg;
    logic [CW-1:0]        cnt_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic [2*WIDTH-1:0]   product_reg;

    logic [WIDTH:0]       sum_next;
    logic [2*WIDTH+1:0]   shift_next;
    logic [WIDTH:0]       a_next;
    logic [WIDTH-1:0]     q_next;
    logic                 q_m1_next;
    logic [2*WIDTH-1:0]   product_next;

    // One Booth step: conditional +M / -M, then arithmetic shift of {A, Q, q_m1}.
    always_comb begin
        sum_next = a_reg;
        case ({q_reg[0], q_m1_reg})
            2'b01:   sum_next = a_reg + m_reg;
            2'b10:   sum_next = a_reg - m_reg;
            default: sum_next = a_reg;
        endcase
        // The old q_m1 falls off the right end; the MSB of A is replicated on the left.
        shift_next   = {sum_next[WIDTH], sum_next, q_reg};
        a_next       = shift_next[2*WIDTH+1:WIDTH+1];
        q_next       = shift_next[WIDTH:1];
        q_m1_next    = shift_next[0];
        product_next = {a_next[WIDTH-1:0], q_next};
    end

    // Control FSM and datapath registers; outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            m_reg       <= '0;
            q_reg       <= '0;
            q_m1_reg    <= 1'b0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg     <= '0;
                        m_reg     <= {mcand[WIDTH-1], mcand};
                        q_reg     <= mplier;
                        q_m1_reg  <= 1'b0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    a_reg    <= a_next;
                    q_reg    <= q_next;
                    q_m1_reg <= q_m1_next;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        product_reg <= product_next;
                        state_reg   <= DONE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = product_reg;

endmodule
